// File: rtl/onn_pkg.sv
// Shared definitions for the ONN settle sequencer: FSM state encoding and array constants.
package onn_pkg;

  localparam int ONN_N_NEURONS = 15;
  localparam int ONN_PHASE_W   = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_LOAD  = 3'd2,
    ST_RUN   = 3'd3,
    ST_CHECK = 3'd4,
    ST_EVAL  = 3'd5,
    ST_DONE  = 3'd6
  } onn_state_e;

endpackage

// File: rtl/onn_popcount.sv
// Combinational population count of an N-bit vector.
module onn_popcount #(
  parameter int N = 15,
  parameter int W = $clog2(N + 1)
) (
  input  logic [N-1:0] vec_i,
  output logic [W-1:0] cnt_o
);

  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < N; i++) begin
      cnt_o = cnt_o + W'(vec_i[i]);
    end
  end

endmodule

// File: rtl/onn_settle_ctrl.sv
// Settle sequencer for the ONN phase-register array: clear, load, periodic check, convergence/timeout.
// Optional build macro CHANGE_COUNT_EN adds the change_cnt activity output.
module onn_settle_ctrl
  import onn_pkg::*;
#(
  parameter int N_NEURONS     = ONN_N_NEURONS,
  parameter int CHECK_PERIOD  = 16,
  parameter int STABLE_CHECKS = 3,
  parameter int MAX_CHECKS    = 64
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic                              abort,
  input  logic [N_NEURONS-1:0]              state_changed_i,
  output logic                              pr_re,
  output logic                              pr_drop,
  output logic                              pr_check,
  output logic                              busy,
  output logic                              done,
  output logic                              converged,
  output logic                              timeout,
  output logic [$clog2(MAX_CHECKS+1)-1:0]   check_cnt
`ifdef CHANGE_COUNT_EN
  ,
  output logic [$clog2(N_NEURONS+1)-1:0]    change_cnt
`endif
);

  localparam int CNT_W = $clog2(MAX_CHECKS + 1);
  localparam int STB_W = $clog2(STABLE_CHECKS + 1);
  localparam int PER_W = $clog2(CHECK_PERIOD + 1);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_CHECKS);
  localparam logic [STB_W-1:0] STB_TGT  = STB_W'(STABLE_CHECKS);
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(CHECK_PERIOD - 1);

  onn_state_e       state_q;
  logic [PER_W-1:0] period_q;
  logic [STB_W-1:0] stable_q, stable_d;
  logic [CNT_W-1:0] check_cnt_q;
  logic             pr_re_q, pr_drop_q, pr_check_q;
  logic             busy_q, done_q, converged_q, timeout_q;
  logic             run_start;

  assign run_start = (state_q == ST_IDLE) && start && !abort;

  // Stability count after this check; stable_q never exceeds the target.
  always_comb begin
    stable_d = stable_q;
    if (|state_changed_i) begin
      stable_d = '0;
    end else if (stable_q != STB_TGT) begin
      stable_d = stable_q + STB_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      period_q    <= '0;
      stable_q    <= '0;
      check_cnt_q <= '0;
      pr_re_q     <= 1'b0;
      pr_drop_q   <= 1'b0;
      pr_check_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      converged_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      pr_re_q    <= 1'b0;
      pr_drop_q  <= 1'b0;
      pr_check_q <= 1'b0;
      done_q     <= 1'b0;
      if (abort && (state_q != ST_IDLE)) begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (run_start) begin
              state_q     <= ST_CLEAR;
              pr_re_q     <= 1'b1;
              busy_q      <= 1'b1;
              converged_q <= 1'b0;
              timeout_q   <= 1'b0;
              check_cnt_q <= '0;
              stable_q    <= '0;
            end
          end
          ST_CLEAR: begin
            state_q   <= ST_LOAD;
            pr_drop_q <= 1'b1;
          end
          ST_LOAD: begin
            state_q  <= ST_RUN;
            period_q <= '0;
          end
          ST_RUN: begin
            if (period_q == PER_LAST) begin
              state_q    <= ST_CHECK;
              pr_check_q <= 1'b1;
            end else begin
              period_q <= period_q + PER_W'(1);
            end
          end
          ST_CHECK: begin
            state_q     <= ST_EVAL;
            check_cnt_q <= check_cnt_q + CNT_W'(1);
          end
          ST_EVAL: begin
            stable_q <= stable_d;
            // Convergence wins over timeout when both land on the same check.
            if (stable_d == STB_TGT) begin
              state_q     <= ST_DONE;
              converged_q <= 1'b1;
              done_q      <= 1'b1;
            end else if (check_cnt_q == CNT_MAX) begin
              state_q   <= ST_DONE;
              timeout_q <= 1'b1;
              done_q    <= 1'b1;
            end else begin
              state_q  <= ST_RUN;
              period_q <= '0;
            end
          end
          ST_DONE: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign pr_re     = pr_re_q;
  assign pr_drop   = pr_drop_q;
  assign pr_check  = pr_check_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign converged = converged_q;
  assign timeout   = timeout_q;
  assign check_cnt = check_cnt_q;

`ifdef CHANGE_COUNT_EN
  localparam int CHG_W = $clog2(N_NEURONS + 1);

  logic [CHG_W-1:0] pop_cnt;
  logic [CHG_W-1:0] change_cnt_q;

  onn_popcount #(
    .N (N_NEURONS),
    .W (CHG_W)
  ) u_popcount (
    .vec_i (state_changed_i),
    .cnt_o (pop_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      change_cnt_q <= '0;
    end else if (run_start) begin
      change_cnt_q <= '0;
    end else if ((state_q == ST_EVAL) && !abort) begin
      change_cnt_q <= pop_cnt;
    end
  end

  assign change_cnt = change_cnt_q;
`endif

endmodule
